// File: rtl/manhattan_pipe_pkg.sv
// rtl/manhattan_pipe_pkg.sv - shared width helpers for the L1 distance pipeline
package manhattan_pipe_pkg;

  // Split-axis index width; a single-coordinate point still gets one bit.
  function automatic int axis_w(input int dim);
    return (dim <= 1) ? 1 : $clog2(dim);
  endfunction

  // Distance width holds dim*(2^data_w-1) with no overflow.
  function automatic int dist_w(input int dim, input int data_w);
    return data_w + ((dim <= 1) ? 1 : $clog2(dim));
  endfunction

endpackage

// File: rtl/manhattan_pipe_abs_diff.sv
// rtl/manhattan_pipe_abs_diff.sv - combinational exact |a-b| on unsigned coordinates
module manhattan_pipe_abs_diff #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W:0] diff;

  assign diff = {1'b0, a} - {1'b0, b};
  assign y    = diff[DATA_W] ? DATA_W'(-diff) : diff[DATA_W-1:0];

endmodule

// File: rtl/manhattan_pipe.sv
// rtl/manhattan_pipe.sv - 3-stage L1 distance engine for kd-tree search with valid/ready flow
module manhattan_pipe
  import manhattan_pipe_pkg::*;
#(
  parameter  int DIM    = 3,
  parameter  int DATA_W = 8,
  parameter  int TAG_W  = 4,
  localparam int AXIS_W = axis_w(DIM),
  localparam int DIST_W = dist_w(DIM, DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AXIS_W-1:0]     in_axis,
  input  logic [DIM*DATA_W-1:0] in_query,
  input  logic [DIM*DATA_W-1:0] in_node,
  input  logic [DIM*DATA_W-1:0] in_best,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIST_W-1:0]     out_dist_node,
  output logic [DIST_W-1:0]     out_dist_best,
  output logic [DATA_W-1:0]     out_axis_dist,
  output logic                  out_node_closer,
  output logic                  out_axis_oob,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  busy
);

  logic load1, load2, load3;
  logic v1, v2;

  // Each stage refills when empty or when the stage downstream moves on.
  assign load3    = ~out_valid | out_ready;
  assign load2    = ~v2 | load3;
  assign load1    = ~v1 | load2;
  assign in_ready = load1;
  assign busy     = v1 | v2 | out_valid;

  logic [DATA_W-1:0] dn_c [DIM];
  logic [DATA_W-1:0] db_c [DIM];
  logic [DATA_W-1:0] axis_c;
  logic              oob_c;

  for (genvar k = 0; k < DIM; k++) begin : g_diff
    manhattan_pipe_abs_diff #(.DATA_W(DATA_W)) u_dn (
      .a (in_query[k*DATA_W +: DATA_W]),
      .b (in_node[k*DATA_W +: DATA_W]),
      .y (dn_c[k])
    );
    manhattan_pipe_abs_diff #(.DATA_W(DATA_W)) u_db (
      .a (in_query[k*DATA_W +: DATA_W]),
      .b (in_best[k*DATA_W +: DATA_W]),
      .y (db_c[k])
    );
  end

  // An axis matching no coordinate is flagged out of range and reads as zero.
  always_comb begin
    axis_c = '0;
    oob_c  = 1'b1;
    for (int k = 0; k < DIM; k++) begin
      if (in_axis == AXIS_W'(k)) begin
        axis_c = dn_c[k];
        oob_c  = 1'b0;
      end
    end
  end

  logic [DATA_W-1:0] dn1 [DIM];
  logic [DATA_W-1:0] db1 [DIM];
  logic [DATA_W-1:0] axis1;
  logic              oob1;
  logic [TAG_W-1:0]  tag1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1    <= 1'b0;
      axis1 <= '0;
      oob1  <= 1'b0;
      tag1  <= '0;
      for (int k = 0; k < DIM; k++) begin
        dn1[k] <= '0;
        db1[k] <= '0;
      end
    end else if (load1) begin
      v1 <= in_valid;
      if (in_valid) begin
        axis1 <= axis_c;
        oob1  <= oob_c;
        tag1  <= in_tag;
        for (int k = 0; k < DIM; k++) begin
          dn1[k] <= dn_c[k];
          db1[k] <= db_c[k];
        end
      end
    end
  end

  logic [DIST_W-1:0] sum_n, sum_b;

  always_comb begin
    sum_n = '0;
    sum_b = '0;
    for (int k = 0; k < DIM; k++) begin
      sum_n = sum_n + DIST_W'(dn1[k]);
      sum_b = sum_b + DIST_W'(db1[k]);
    end
  end

  logic [DIST_W-1:0] sn2, sb2;
  logic [DATA_W-1:0] axis2;
  logic              oob2;
  logic [TAG_W-1:0]  tag2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2    <= 1'b0;
      sn2   <= '0;
      sb2   <= '0;
      axis2 <= '0;
      oob2  <= 1'b0;
      tag2  <= '0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        sn2   <= sum_n;
        sb2   <= sum_b;
        axis2 <= axis1;
        oob2  <= oob1;
        tag2  <= tag1;
      end
    end
  end

  // Ties keep the incumbent best: closer only on strict less-than.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid       <= 1'b0;
      out_dist_node   <= '0;
      out_dist_best   <= '0;
      out_axis_dist   <= '0;
      out_node_closer <= 1'b0;
      out_axis_oob    <= 1'b0;
      out_tag         <= '0;
    end else if (load3) begin
      out_valid <= v2;
      if (v2) begin
        out_dist_node   <= sn2;
        out_dist_best   <= sb2;
        out_axis_dist   <= axis2;
        out_node_closer <= (sn2 < sb2);
        out_axis_oob    <= oob2;
        out_tag         <= tag2;
      end
    end
  end

endmodule

// File: tb/tb_manhattan_pipe.sv
// tb/tb_manhattan_pipe.sv - self-checking bench for manhattan_pipe over three parameter sets
module tb_manhattan_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input int cfg, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s cfg%0d: got %0d required %0d", nm, cfg, got, want);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int D  = (g == 0) ? 3 : (g == 1) ? 4 : 1;
    localparam int W  = (g == 1) ? 12 : 8;
    localparam int AW = (D <= 1) ? 1 : $clog2(D);
    localparam int DW = W + ((D <= 1) ? 1 : $clog2(D));
    localparam int TW = 4;

    logic            rst, in_valid, in_ready, out_valid, out_node_closer, out_axis_oob, busy;
    logic            out_ready = 1'b1;
    logic [AW-1:0]   in_axis;
    logic [D*W-1:0]  in_query, in_node, in_best;
    logic [TW-1:0]   in_tag, out_tag;
    logic [DW-1:0]   out_dist_node, out_dist_best;
    logic [W-1:0]    out_axis_dist;

    int phase = 0;
    int ncyc = 0;
    int ready_mode = 1;
    int tagc = 0;
    bit done_flag = 1'b0;
    int q_node[$], q_best[$], q_axis[$], q_closer[$], q_oob[$], q_tag[$], q_cyc[$];

    manhattan_pipe #(.DIM(D), .DATA_W(W), .TAG_W(TW)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_axis         (in_axis),
      .in_query        (in_query),
      .in_node         (in_node),
      .in_best         (in_best),
      .in_tag          (in_tag),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_dist_node   (out_dist_node),
      .out_dist_best   (out_dist_best),
      .out_axis_dist   (out_axis_dist),
      .out_node_closer (out_node_closer),
      .out_axis_oob    (out_axis_oob),
      .out_tag         (out_tag),
      .busy            (busy)
    );

    function automatic int coord(input logic [D*W-1:0] p, input int k);
      return int'(p[k*W +: W]);
    endfunction

    function automatic int l1(input logic [D*W-1:0] p, input logic [D*W-1:0] r);
      int s = 0;
      for (int k = 0; k < D; k++)
        s += (coord(p, k) > coord(r, k)) ? coord(p, k) - coord(r, k) : coord(r, k) - coord(p, k);
      return s;
    endfunction

    function automatic logic [D*W-1:0] rpt();
      logic [D*W-1:0] p;
      for (int k = 0; k < D; k++) p[k*W +: W] = W'($urandom);
      return p;
    endfunction

    initial begin
      forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
          0:       out_ready = 1'b0;
          1:       out_ready = 1'b1;
          default: out_ready = ($urandom_range(0, 9) >= 3);
        endcase
      end
    end

    // Scoreboard: model results are queued on accept, compared on consume.
    initial begin
      logic pv, pr, pcl, pob;
      logic [DW-1:0] pn, pb;
      logic [W-1:0] pa;
      logic [TW-1:0] pt;
      int len, ax, dq;
      pv = 1'b0;
      pr = 1'b0;
      forever begin
        @(negedge clk);
        ncyc++;
        if (rst !== 1'b1) begin
          q_node.delete(); q_best.delete(); q_axis.delete(); q_closer.delete();
          q_oob.delete(); q_tag.delete(); q_cyc.delete();
          chk("rst_out_valid", g, out_valid, 0);
          chk("rst_busy", g, busy, 0);
          pv = 1'b0;
        end else begin
          len = q_tag.size();
          chk("busy", g, busy, len != 0);
          chk("in_ready", g, in_ready, !(len == 3 && !out_ready));
          if (pv && !pr) begin
            chk("hold_valid", g, out_valid, 1);
            chk("hold_node", g, out_dist_node, pn);
            chk("hold_best", g, out_dist_best, pb);
            chk("hold_axis", g, out_axis_dist, pa);
            chk("hold_closer", g, out_node_closer, pcl);
            chk("hold_oob", g, out_axis_oob, pob);
            chk("hold_tag", g, out_tag, pt);
          end
          if (in_valid && in_ready) begin
            ax = int'(in_axis);
            dq = l1(in_query, in_node);
            q_node.push_back(dq);
            q_best.push_back(l1(in_query, in_best));
            q_axis.push_back(ax < D ? ((coord(in_query, ax) > coord(in_node, ax)) ?
                             coord(in_query, ax) - coord(in_node, ax) :
                             coord(in_node, ax) - coord(in_query, ax)) : 0);
            q_closer.push_back(dq < l1(in_query, in_best));
            q_oob.push_back(ax >= D);
            q_tag.push_back(int'(in_tag));
            q_cyc.push_back(ncyc);
          end
          if (out_valid && out_ready) begin
            if (len == 0) chk("spurious_out", g, out_valid, 0);
            else begin
              chk("dist_node", g, out_dist_node, q_node.pop_front());
              chk("dist_best", g, out_dist_best, q_best.pop_front());
              chk("axis_dist", g, out_axis_dist, q_axis.pop_front());
              chk("closer", g, out_node_closer, q_closer.pop_front());
              chk("axis_oob", g, out_axis_oob, q_oob.pop_front());
              chk("tag", g, out_tag, q_tag.pop_front());
              if (phase == 1) chk("latency", g, ncyc - q_cyc[0], 3);
              void'(q_cyc.pop_front());
            end
          end
          pv = out_valid; pr = out_ready; pn = out_dist_node; pb = out_dist_best;
          pa = out_axis_dist; pcl = out_node_closer; pob = out_axis_oob; pt = out_tag;
        end
      end
    end

    task automatic send(input logic [D*W-1:0] q, input logic [D*W-1:0] n,
                        input logic [D*W-1:0] b, input int ax);
      int guard = 0;
      logic acc;
      in_query = q; in_node = n; in_best = b;
      in_axis  = AW'(ax);
      in_tag   = TW'(tagc);
      in_valid = 1'b1;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!acc && guard < 1000);
      if (!acc) chk("send_timeout", g, in_ready, 1);
      tagc++;
    endtask

    task automatic drain();
      int guard = 0;
      while (q_tag.size() != 0 && guard < 500) begin
        @(posedge clk);
        #1;
        guard++;
      end
      chk("drain", g, q_tag.size(), 0);
    endtask

    initial begin
      int tq[4] = '{10, 20, 30, 40};
      int tn[4] = '{13, 15, 30, 41};
      int uq[4] = '{1, 2, 3, 4};
      int un[4] = '{4, 6, 8, 9};
      int ub[4] = '{1, 2, 4, 5};
      logic [D*W-1:0] q, n, b;
      rst = 1'b0; in_valid = 1'b0; in_axis = '0; in_tag = '0;
      in_query = '0; in_node = '0; in_best = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", g, out_valid, 0);
      chk("reset_busy", g, busy, 0);
      chk("reset_out_node", g, out_dist_node, 0);
      chk("reset_out_best", g, out_dist_best, 0);
      chk("reset_out_tag", g, out_tag, 0);
      chk("reset_closer", g, out_node_closer, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_in_ready", g, in_ready, 1);

      phase = 1;
      for (int k = 0; k < D; k++) begin
        q[k*W +: W] = W'(tq[k]); n[k*W +: W] = W'(tn[k]);
      end
      send(q, n, '0, 0);
      q = '1;
      send(q, '0, q, (D > 1) ? 1 : 0);
      for (int k = 0; k < D; k++) q[k*W +: W] = W'(7);
      send(q, q, q, (D > 2) ? 2 : 0);
      for (int k = 0; k < D; k++) begin
        q[k*W +: W] = W'(uq[k]); n[k*W +: W] = W'(un[k]); b[k*W +: W] = W'(ub[k]);
      end
      send(q, n, b, (1 << AW) - 1);
      for (int i = 0; i < 20; i++) send(rpt(), rpt(), rpt(), $urandom_range(0, (1 << AW) - 1));
      in_valid = 1'b0;
      drain();

      phase = 2;
      ready_mode = 2;
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        send(rpt(), rpt(), rpt(), $urandom_range(0, (1 << AW) - 1));
      end
      in_valid = 1'b0;
      drain();

      phase = 3;
      ready_mode = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) send(rpt(), rpt(), rpt(), 0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      ready_mode = 1;
      repeat (8) @(posedge clk);
      #1;
      chk("post_rst_out_valid", g, out_valid, 0);
      send(rpt(), rpt(), rpt(), 0);
      send(rpt(), rpt(), rpt(), 0);
      in_valid = 1'b0;
      drain();
      done_flag = 1'b1;
    end
  end

  // Hand-computed results for the first four DIM=3, DATA_W=8 transactions.
  initial begin
    int lit_node[4]   = '{8, 765, 0, 12};
    int lit_best[4]   = '{60, 0, 0, 1};
    int lit_axis[4]   = '{3, 255, 0, 0};
    int lit_closer[4] = '{1, 0, 0, 0};
    int lit_oob[4]    = '{0, 0, 0, 1};
    int idx = 0;
    forever begin
      @(negedge clk);
      if (g_cfg[0].rst === 1'b1 && g_cfg[0].out_valid && g_cfg[0].out_ready && idx < 4) begin
        chk("lit_node", idx, g_cfg[0].out_dist_node, lit_node[idx]);
        chk("lit_best", idx, g_cfg[0].out_dist_best, lit_best[idx]);
        chk("lit_axis", idx, g_cfg[0].out_axis_dist, lit_axis[idx]);
        chk("lit_closer", idx, g_cfg[0].out_node_closer, lit_closer[idx]);
        chk("lit_oob", idx, g_cfg[0].out_axis_oob, lit_oob[idx]);
        chk("lit_tag", idx, g_cfg[0].out_tag, idx);
        idx++;
      end
    end
  end

  initial begin
    int guard = 0;
    while (!(g_cfg[0].done_flag && g_cfg[1].done_flag && g_cfg[2].done_flag) && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    chk("all_done", 0, int'(g_cfg[0].done_flag) + int'(g_cfg[1].done_flag) + int'(g_cfg[2].done_flag), 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
